spi_reg_controller: RTL and testbench
=====================================

SPI_REG_CONTROLLER -- requirements
Module: spi_reg_controller

Interface
REQ-001 SHALL have parameter NUM_REGS, default 5, number of writable 8-bit registers (addresses 0..NUM_REGS-1).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, flip-flop depth of each input synchroniser (minimum 2).
REQ-003 SHALL have ports as follows, clock and reset first:
 clk  in  1  single system clock; all logic on rising edge.
 rst  in  1  synchronous, active-high reset.
 sclk  in  1  raw SPI clock, asynchronous to clk.
 copi  in  1  raw SPI data (controller-out), asynchronous.
 ncs  in  1  raw SPI chip select, active-low, asynchronous.
 reg_0..reg_4  out  8 each  register bank contents.
 wr_strobe  out  1  one-cycle pulse on each committed write.
 wr_addr  out  7  address of last committed write.
 frame_err  out  1  one-cycle pulse on each discarded malformed frame.
 err_count  out  8  saturating count of malformed frames.
 busy  out  1  high while state is not IDLE.

Function
REQ-004 SHALL pass sclk, copi and ncs through SYNC_STAGES-deep synchronisers before any use.
REQ-005 SHALL detect sclk_rise and ncs_fall/ncs_rise by comparing each synchronised signal against a one-cycle-delayed copy.
REQ-006 SHALL implement FSM states IDLE, SHIFT, COMMIT and DRAIN.
REQ-007 IDLE -> SHIFT on ncs_fall; on entry, bit_cnt (5-bit) and shift_reg (16-bit) SHALL clear.
REQ-008 In SHIFT, each sclk_rise SHALL shift synchronised copi into shift_reg LSB, MSB first.
REQ-009 In SHIFT, each sclk_rise SHALL increment bit_cnt, saturating at 17 (overrun marker).
REQ-010 SHIFT -> COMMIT on ncs_rise; an sclk_rise in the same clk cycle SHALL be ignored.
REQ-011 In COMMIT, a frame SHALL be valid only if bit_cnt==16, shift_reg[15]==1 (write) and shift_reg[14:8] < NUM_REGS.
REQ-012 For a valid frame, the addressed register SHALL take shift_reg[7:0], wr_addr SHALL take shift_reg[14:8], and wr_strobe SHALL be high for that one cycle; the new value SHALL be visible in the same cycle wr_strobe is high.
REQ-013 A frame with bit_cnt != 16 SHALL be discarded with no register change, with frame_err pulsed and err_count incremented, saturating at 0xFF.
REQ-014 A 16-bit read frame (bit 15 == 0) or an out-of-range address SHALL be silently ignored: no register change, no wr_strobe, no frame_err.
REQ-015 COMMIT SHALL last exactly one cycle and then go to IDLE.
REQ-016 Write latency from the synchronised ncs rising edge to wr_strobe SHALL be exactly 2 clk cycles: detect, then COMMIT.
REQ-017 DRAIN SHALL wait until synchronised ncs==1 and then go to IDLE, with no shifting and no error counting.
REQ-018 An ncs_fall while in COMMIT SHALL be ignored; the frame beginning in that cycle is lost, and the controller recovers at the next ncs_fall from IDLE.
REQ-019 wr_strobe and frame_err SHALL never be high in the same cycle.

Reset
REQ-020 On clk edge with rst=1, SHALL set reg_0..reg_4=0x00, wr_addr=0, wr_strobe=0, frame_err=0, err_count=0, bit_cnt=0, shift_reg=0.
REQ-021 On reset, synchroniser and edge-detect flops SHALL be set to the idle level: sclk=0, copi=0, ncs=1.
REQ-022 Reset SHALL put the FSM in DRAIN, so a frame already in progress at reset release is never partially captured.
REQ-023 Reset asserted mid-frame SHALL abort the frame with no register change and no err_count increment.

Structure
REQ-024 A shared package SHALL hold the FSM state enum, the FRAME_BITS=16 constant and the WRITE_BIT=15 constant.
REQ-025 The synchroniser SHALL be one sub-module, sync_ff (1-bit, SYNC_STAGES parameter), instantiated three times.
REQ-026 All other logic (edge detection, FSM, register bank, error counter) SHALL stay in spi_reg_controller.

Verification
REQ-027 Frame 0x80A5 (16 bits) -> reg_0=0xA5, wr_addr=0, one wr_strobe, err_count=0.
REQ-028 Frame 0x84FF -> reg_4=0xFF; then frame 0x8511 (address 5) -> no change, no strobe, no frame_err.
REQ-029 Read frame 0x0155 -> reg_1 unchanged, no strobe, no frame_err.
REQ-030 15-bit frame, then 17-bit frame -> no register change, two frame_err pulses, err_count=2; 256 bad frames -> err_count=0xFF.
REQ-031 rst pulse after 8 bits of 0x8233, with ncs still low -> stays in DRAIN, reg_2=0x00; next full 0x8233 frame -> reg_2=0x33.
REQ-032 Back-to-back frames 0x8011 and 0x8122 with 4 clk of ncs high between them -> reg_0=0x11, reg_1=0x22, two wr_strobe pulses.

Source files
------------

// File: rtl/spi_reg_controller_pkg.sv
// Shared types and constants for the SPI register controller.
package spi_reg_controller_pkg;

  // Bits in a well-formed write frame: {wr, addr[6:0], data[7:0]}.
  localparam int FRAME_BITS = 16;
  // Position of the write/read flag within a completed frame.
  localparam int WRITE_BIT  = 15;
  // Number of registers exposed on dedicated output ports.
  localparam int PORT_REGS  = 5;
  // Bit counter value that marks "more than FRAME_BITS bits seen".
  localparam logic [4:0] BIT_CNT_SAT = 5'd17;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2,
    ST_DRAIN  = 2'd3
  } state_t;

  // Increment the bit counter, sticking at the overrun marker.
  function automatic logic [4:0] bit_cnt_inc(input logic [4:0] cnt);
    return (cnt >= BIT_CNT_SAT) ? BIT_CNT_SAT : cnt + 5'd1;
  endfunction

endpackage

// File: rtl/spi_reg_controller_sync_ff.sv
// Multi-flop synchroniser for one asynchronous bit, reset to a chosen idle level.
module sync_ff #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] stage_reg;

  // Shift the raw input through the flop chain; reset loads the idle level.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_reg <= {SYNC_STAGES{RESET_VAL}};
    end else begin
      stage_reg <= {stage_reg[SYNC_STAGES-2:0], d};
    end
  end

  assign q = stage_reg[SYNC_STAGES-1];

endmodule

// File: rtl/spi_reg_controller.sv
// SPI write-only register controller: synchronises the raw SPI pins into the
// clk domain, assembles 16-bit frames and commits valid writes to a register bank.
module spi_reg_controller
  import spi_reg_controller_pkg::*;
#(
  parameter int NUM_REGS    = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic [7:0] reg_0,
  output logic [7:0] reg_1,
  output logic [7:0] reg_2,
  output logic [7:0] reg_3,
  output logic [7:0] reg_4,
  output logic       wr_strobe,
  output logic [6:0] wr_addr,
  output logic       frame_err,
  output logic [7:0] err_count,
  output logic       busy
);

  localparam logic [7:0] NUM_REGS_W = 8'(NUM_REGS);

  genvar gi;

  // ---------------------------------------------------------------------------
  // Input synchronisers (idle levels: sclk=0, copi=0, ncs=1)
  // ---------------------------------------------------------------------------
  logic sclk_s;
  logic copi_s;
  logic ncs_s;

  sync_ff #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk (clk),
    .rst (rst),
    .d   (sclk),
    .q   (sclk_s)
  );

  sync_ff #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_copi (
    .clk (clk),
    .rst (rst),
    .d   (copi),
    .q   (copi_s)
  );

  sync_ff #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ncs (
    .clk (clk),
    .rst (rst),
    .d   (ncs),
    .q   (ncs_s)
  );

  // ---------------------------------------------------------------------------
  // Edge detection
  // ---------------------------------------------------------------------------
  logic sclk_dly_reg;
  logic ncs_dly_reg;
  logic sclk_rise;
  logic ncs_fall;
  logic ncs_rise;

  // One-cycle-delayed copies of the synchronised clock and select.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_dly_reg <= 1'b0;
      ncs_dly_reg  <= 1'b1;
    end else begin
      sclk_dly_reg <= sclk_s;
      ncs_dly_reg  <= ncs_s;
    end
  end

  assign sclk_rise = sclk_s & ~sclk_dly_reg;
  assign ncs_fall  = ~ncs_s & ncs_dly_reg;
  assign ncs_rise  = ncs_s & ~ncs_dly_reg;

  // ---------------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------------
  state_t      state_reg;
  state_t      state_next;
  logic [4:0]  bit_cnt_reg;
  logic [4:0]  bit_cnt_next;
  logic [15:0] shift_reg;
  logic [15:0] shift_next;
  // After reset the synchronisers hold the idle level rather than the pin, so
  // DRAIN must not trust ncs_s until the chain has refilled from the real pin.
  logic [7:0]  settle_reg;

  // State register; reset parks in DRAIN so a frame in flight is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_DRAIN;
    end else begin
      state_reg <= state_next;
    end
  end

  // Frame datapath registers: bit counter, shift register, settle counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_reg <= 5'd0;
      shift_reg   <= 16'h0000;
      settle_reg  <= 8'(SYNC_STAGES);
    end else begin
      bit_cnt_reg <= bit_cnt_next;
      shift_reg   <= shift_next;
      if (settle_reg != 8'd0) begin
        settle_reg <= settle_reg - 8'd1;
      end
    end
  end

  // Next-state and frame assembly.
  always_comb begin
    state_next   = state_reg;
    bit_cnt_next = bit_cnt_reg;
    shift_next   = shift_reg;
    case (state_reg)
      ST_IDLE: begin
        if (ncs_fall) begin
          state_next   = ST_SHIFT;
          bit_cnt_next = 5'd0;
          shift_next   = 16'h0000;
        end
      end
      ST_SHIFT: begin
        // End of frame wins over a simultaneous clock edge.
        if (ncs_rise) begin
          state_next = ST_COMMIT;
        end else if (sclk_rise) begin
          shift_next   = {shift_reg[14:0], copi_s};
          bit_cnt_next = bit_cnt_inc(bit_cnt_reg);
        end
      end
      ST_COMMIT: begin
        // Single-cycle decision; any ncs_fall seen here is deliberately lost.
        state_next = ST_IDLE;
      end
      ST_DRAIN: begin
        if ((settle_reg == 8'd0) && ncs_s) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_DRAIN;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Commit decode
  // ---------------------------------------------------------------------------
  logic       frame_full;
  logic [6:0] frame_addr;
  logic [7:0] frame_data;
  logic       addr_in_range;
  logic       commit_write;
  logic       commit_bad;

  assign frame_full    = (bit_cnt_reg == 5'(FRAME_BITS));
  assign frame_addr    = shift_reg[14:8];
  assign frame_data    = shift_reg[7:0];
  assign addr_in_range = ({1'b0, frame_addr} < NUM_REGS_W);
  assign commit_write  = (state_reg == ST_COMMIT) && frame_full &&
                         shift_reg[WRITE_BIT] && addr_in_range;
  // Only wrong-length frames are errors; reads and bad addresses are ignored.
  assign commit_bad    = (state_reg == ST_COMMIT) && !frame_full;

  // ---------------------------------------------------------------------------
  // Status outputs and error counter
  // ---------------------------------------------------------------------------
  logic       wr_strobe_reg;
  logic       frame_err_reg;
  logic [6:0] wr_addr_reg;
  logic [7:0] err_count_reg;

  // Registered strobes land in the same cycle as the register bank update.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_strobe_reg <= 1'b0;
      frame_err_reg <= 1'b0;
      wr_addr_reg   <= 7'd0;
      err_count_reg <= 8'd0;
    end else begin
      wr_strobe_reg <= commit_write;
      frame_err_reg <= commit_bad;
      if (commit_write) begin
        wr_addr_reg <= frame_addr;
      end
      if (commit_bad && (err_count_reg != 8'hFF)) begin
        err_count_reg <= err_count_reg + 8'd1;
      end
    end
  end

  assign wr_strobe = wr_strobe_reg;
  assign frame_err = frame_err_reg;
  assign wr_addr   = wr_addr_reg;
  assign err_count = err_count_reg;
  assign busy      = (state_reg != ST_IDLE);

  // ---------------------------------------------------------------------------
  // Register bank
  // ---------------------------------------------------------------------------
  logic [7:0] bank [NUM_REGS];

  for (gi = 0; gi < NUM_REGS; gi++) begin : gen_bank
    logic [7:0] data_reg;

    // Load this register when a valid write addresses it.
    always_ff @(posedge clk) begin
      if (rst) begin
        data_reg <= 8'h00;
      end else if (commit_write && (frame_addr == 7'(gi))) begin
        data_reg <= frame_data;
      end
    end

    assign bank[gi] = data_reg;
  end

  // Map the bank onto the fixed output ports; absent registers read as zero.
  logic [7:0] reg_view [PORT_REGS];

  for (gi = 0; gi < PORT_REGS; gi++) begin : gen_view
    if (gi < NUM_REGS) begin : g_map
      assign reg_view[gi] = bank[gi];
    end else begin : g_zero
      assign reg_view[gi] = 8'h00;
    end
  end

  assign reg_0 = reg_view[0];
  assign reg_1 = reg_view[1];
  assign reg_2 = reg_view[2];
  assign reg_3 = reg_view[3];
  assign reg_4 = reg_view[4];

endmodule

// File: tb/tb_spi_reg_controller.sv
// Directed bench for spi_reg_controller: table of frames plus hand sequences
// for latency, back-to-back frames, error saturation and mid-frame reset.
module tb_spi_reg_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       sclk;
  logic       copi;
  logic       ncs;
  logic [7:0] reg_0, reg_1, reg_2, reg_3, reg_4;
  logic       wr_strobe;
  logic [6:0] wr_addr;
  logic       frame_err;
  logic [7:0] err_count;
  logic       busy;

  spi_reg_controller #(.NUM_REGS(5), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .sclk      (sclk),
    .copi      (copi),
    .ncs       (ncs),
    .reg_0     (reg_0),
    .reg_1     (reg_1),
    .reg_2     (reg_2),
    .reg_3     (reg_3),
    .reg_4     (reg_4),
    .wr_strobe (wr_strobe),
    .wr_addr   (wr_addr),
    .frame_err (frame_err),
    .err_count (err_count),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         strobe_cnt = 0;
  int         ferr_cnt   = 0;
  logic [7:0] exp_wdata  = 8'h00;
  logic [7:0] regs_tb [5];

  assign regs_tb[0] = reg_0;
  assign regs_tb[1] = reg_1;
  assign regs_tb[2] = reg_2;
  assign regs_tb[3] = reg_3;
  assign regs_tb[4] = reg_4;

  typedef struct {
    logic [31:0] frame;
    int          nbits;
    int          exp_strobe;
    int          exp_ferr;
    int          chk_idx;
    logic [7:0]  chk_val;
    logic [7:0]  exp_errcnt;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic shift_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      copi = v[i];
      tick(4);
      sclk = 1'b1;
      tick(4);
      sclk = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [31:0] v, input int n, input int gap);
    ncs = 1'b0;
    tick(4);
    shift_bits(v, n);
    tick(4);
    exp_wdata = v[7:0];
    ncs = 1'b1;
    tick(gap);
  endtask

  // Pulse monitor: counts strobes/errors, checks exclusivity and that the
  // written value is already visible while wr_strobe is high.
  always @(negedge clk) begin
    if (!rst && (wr_strobe || frame_err)) begin
      if (wr_strobe) strobe_cnt++;
      if (frame_err) ferr_cnt++;
      check("strobe_err_exclusive", {30'd0, wr_strobe, frame_err} == 32'd3 ? 32'd1 : 32'd0, 32'd0);
      if (wr_strobe && wr_addr < 7'd5) begin
        check("strobe_data_visible", regs_tb[wr_addr], exp_wdata);
      end
    end
  end

  initial begin
    int s0, e0, lat;
    logic found;

    vecs[0] = '{32'h80A5,  16, 1, 0, 0, 8'hA5, 8'h00};
    vecs[1] = '{32'h84FF,  16, 1, 0, 4, 8'hFF, 8'h00};
    vecs[2] = '{32'h8511,  16, 0, 0, 4, 8'hFF, 8'h00};
    vecs[3] = '{32'h0155,  16, 0, 0, 1, 8'h00, 8'h00};
    vecs[4] = '{32'h0A5A,  15, 0, 1, 0, 8'hA5, 8'h01};
    vecs[5] = '{32'h18177, 17, 0, 1, 1, 8'h00, 8'h02};
    vecs[6] = '{32'h8312,  16, 1, 0, 3, 8'h12, 8'h02};
    vecs[7] = '{32'h82C3,  16, 1, 0, 2, 8'hC3, 8'h02};

    // Reset state
    rst = 1'b1; sclk = 1'b0; copi = 1'b0; ncs = 1'b1;
    tick(3);
    check("reset_busy", busy, 1);
    check("reset_reg0", reg_0, 0);
    check("reset_reg4", reg_4, 0);
    check("reset_strobe", wr_strobe, 0);
    check("reset_ferr", frame_err, 0);
    check("reset_errcnt", err_count, 0);
    check("reset_wraddr", wr_addr, 0);
    rst = 1'b0;
    tick(5);
    check("idle_after_reset", busy, 0);

    // Table-driven frames
    for (int i = 0; i < 8; i++) begin
      s0 = strobe_cnt;
      e0 = ferr_cnt;
      send_frame(vecs[i].frame, vecs[i].nbits, 12);
      check($sformatf("vec%0d_strobes", i), strobe_cnt - s0, vecs[i].exp_strobe);
      check($sformatf("vec%0d_ferr", i), ferr_cnt - e0, vecs[i].exp_ferr);
      check($sformatf("vec%0d_reg%0d", i, vecs[i].chk_idx), regs_tb[vecs[i].chk_idx], vecs[i].chk_val);
      check($sformatf("vec%0d_errcnt", i), err_count, vecs[i].exp_errcnt);
      if (vecs[i].exp_strobe != 0) begin
        check($sformatf("vec%0d_wraddr", i), wr_addr, vecs[i].frame[14:8]);
      end
      $display("vec %0d frame=0x%0h bits=%0d strobes=%0d ferr=%0d errcnt=%0d",
               i, vecs[i].frame, vecs[i].nbits, strobe_cnt - s0, ferr_cnt - e0, err_count);
    end

    // Latency: synchronised ncs rise + detect + COMMIT => strobe 4 clk after pin edge
    ncs = 1'b0;
    tick(4);
    shift_bits(32'h8033, 16);
    tick(4);
    exp_wdata = 8'h33;
    ncs = 1'b1;
    lat = 0;
    found = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      tick(1);
      if (wr_strobe && !found) begin
        lat = c;
        found = 1'b1;
      end
    end
    check("write_latency", lat, 4);
    check("latency_reg0", reg_0, 8'h33);
    $display("latency frame=0x8033 strobe_after=%0d clk", lat);
    tick(4);

    // Back-to-back frames with 4 clk of ncs high between them
    s0 = strobe_cnt;
    send_frame(32'h8011, 16, 4);
    send_frame(32'h8122, 16, 12);
    check("b2b_strobes", strobe_cnt - s0, 2);
    check("b2b_reg0", reg_0, 8'h11);
    check("b2b_reg1", reg_1, 8'h22);
    $display("back-to-back 0x8011,0x8122 strobes=%0d reg0=0x%0h reg1=0x%0h",
             strobe_cnt - s0, reg_0, reg_1);

    // Error counter saturation: two bad frames so far, bring total to 255 then 256
    e0 = ferr_cnt;
    for (int k = 3; k <= 255; k++) begin
      send_frame(32'h1, 1, 6);
    end
    check("errcnt_255", err_count, 8'hFF);
    send_frame(32'h1, 1, 6);
    check("errcnt_saturated", err_count, 8'hFF);
    check("sat_ferr_pulses", ferr_cnt - e0, 254);
    $display("saturation bad_frames=256 errcnt=0x%0h", err_count);

    // Reset mid-frame: 8 bits of 0x8233, reset, rest of frame with ncs still low
    s0 = strobe_cnt;
    ncs = 1'b0;
    tick(4);
    shift_bits(32'h82, 8);
    rst = 1'b1;
    tick(1);
    check("midrst_busy", busy, 1);
    check("midrst_reg0", reg_0, 0);
    check("midrst_errcnt", err_count, 0);
    rst = 1'b0;
    tick(6);
    check("midrst_drain_busy", busy, 1);
    e0 = ferr_cnt;
    shift_bits(32'h33, 8);
    tick(4);
    exp_wdata = 8'h33;
    ncs = 1'b1;
    tick(12);
    check("midrst_reg2", reg_2, 0);
    check("midrst_strobes", strobe_cnt - s0, 0);
    check("midrst_ferr", ferr_cnt - e0, 0);
    check("midrst_errcnt_after", err_count, 0);
    check("midrst_idle", busy, 0);
    send_frame(32'h8233, 16, 12);
    check("post_rst_reg2", reg_2, 8'h33);
    check("post_rst_strobes", strobe_cnt - s0, 1);
    check("post_rst_errcnt", err_count, 0);
    $display("mid-frame reset then 0x8233 reg2=0x%0h strobes=%0d errcnt=%0d",
             reg_2, strobe_cnt - s0, err_count);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
